// File: rtl/tomasulo_pkg.sv
// Shared widths, constants and types for the Tomasulo datapath blocks.
package tomasulo_pkg;
    localparam int DADO_W = 16;
    localparam int TAG_W  = 4;
    localparam int DEST_W = 3;
    localparam int OP_W   = 2;

    localparam logic [TAG_W-1:0] TAG_NENHUM = 4'd0;
    localparam logic [OP_W-1:0]  OP_SUB     = 2'b01;

    typedef enum logic {OCIOSO, ESPERA} estado_t;

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [DADO_W-1:0] vj;
        logic [TAG_W-1:0]  qj;
        logic [DADO_W-1:0] vk;
        logic [TAG_W-1:0]  qk;
        logic [DEST_W-1:0] dest;
    } entrada_t;
endpackage

// File: rtl/seletor_prioridade.sv
// Lowest-index-first priority select over a request vector.
module seletor_prioridade #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/estacao_reserva.sv
// Reservation-station bank feeding one functional unit via the nova/UF_atoa/V_pronto handshake.
module estacao_reserva
    import tomasulo_pkg::*;
#(
    parameter int               NUM_ENT  = 3,
    parameter logic [TAG_W-1:0] TAG_BASE = 4'd1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              emite,
    input  logic [OP_W-1:0]   opcode_in,
    input  logic [DADO_W-1:0] Vj_in,
    input  logic [TAG_W-1:0]  Qj_in,
    input  logic [DADO_W-1:0] Vk_in,
    input  logic [TAG_W-1:0]  Qk_in,
    input  logic [DEST_W-1:0] dest_in,
    output logic              rs_cheia,
    output logic [TAG_W-1:0]  tag_emitida,
    input  logic              cdb_valido,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DADO_W-1:0] cdb_valor,
    input  logic              UF_atoa,
    input  logic              V_pronto,
    output logic              nova,
    output logic [OP_W-1:0]   opcode_out,
    output logic [DADO_W-1:0] Vj_out,
    output logic [DADO_W-1:0] Vk_out,
    output logic [DEST_W-1:0] dest_out,
    output logic [TAG_W-1:0]  Qi_out
);
    localparam int IDX_W = $clog2(NUM_ENT);

    entrada_t [NUM_ENT-1:0] ent_q, ent_d;
    estado_t                estado_q, estado_d;
    logic [IDX_W-1:0]       idx_q, idx_d;

    logic              nova_q, nova_d;
    logic [OP_W-1:0]   op_out_q, op_out_d;
    logic [DADO_W-1:0] vj_out_q, vj_out_d;
    logic [DADO_W-1:0] vk_out_q, vk_out_d;
    logic [DEST_W-1:0] dest_out_q, dest_out_d;
    logic [TAG_W-1:0]  qi_out_q, qi_out_d;

    logic [NUM_ENT-1:0] livre, pronto;
    logic [IDX_W-1:0]   livre_idx, pronto_idx;
    logic               livre_ok, pronto_ok;

    always_comb begin
        for (int i = 0; i < NUM_ENT; i++) begin
            livre[i]  = ~ent_q[i].busy;
            // The entry held by the functional unit must not be picked twice.
            pronto[i] = ent_q[i].busy && (ent_q[i].qj == TAG_NENHUM) &&
                        (ent_q[i].qk == TAG_NENHUM) &&
                        !((estado_q == ESPERA) && (idx_q == IDX_W'(i)));
        end
    end

    seletor_prioridade #(.N(NUM_ENT), .IDX_W(IDX_W)) u_sel_livre (
        .req_i   (livre),
        .idx_o   (livre_idx),
        .valid_o (livre_ok)
    );

    seletor_prioridade #(.N(NUM_ENT), .IDX_W(IDX_W)) u_sel_pronto (
        .req_i   (pronto),
        .idx_o   (pronto_idx),
        .valid_o (pronto_ok)
    );

    assign rs_cheia    = ~livre_ok;
    assign tag_emitida = TAG_BASE + TAG_W'(livre_idx);

    always_comb begin
        ent_d      = ent_q;
        estado_d   = estado_q;
        idx_d      = idx_q;
        nova_d     = 1'b0;
        op_out_d   = op_out_q;
        vj_out_d   = vj_out_q;
        vk_out_d   = vk_out_q;
        dest_out_d = dest_out_q;
        qi_out_d   = qi_out_q;

        for (int i = 0; i < NUM_ENT; i++) begin
            if (cdb_valido && ent_q[i].busy && (ent_q[i].qj != TAG_NENHUM) &&
                (ent_q[i].qj == cdb_tag)) begin
                ent_d[i].vj = cdb_valor;
                ent_d[i].qj = TAG_NENHUM;
            end
            if (cdb_valido && ent_q[i].busy && (ent_q[i].qk != TAG_NENHUM) &&
                (ent_q[i].qk == cdb_tag)) begin
                ent_d[i].vk = cdb_valor;
                ent_d[i].qk = TAG_NENHUM;
            end
        end

        // A broadcast in the issue cycle would otherwise be missed by the new entry.
        if (emite && livre_ok) begin
            ent_d[livre_idx].busy = 1'b1;
            ent_d[livre_idx].op   = opcode_in;
            ent_d[livre_idx].dest = dest_in;
            if (cdb_valido && (Qj_in != TAG_NENHUM) && (Qj_in == cdb_tag)) begin
                ent_d[livre_idx].vj = cdb_valor;
                ent_d[livre_idx].qj = TAG_NENHUM;
            end else begin
                ent_d[livre_idx].vj = Vj_in;
                ent_d[livre_idx].qj = Qj_in;
            end
            if (cdb_valido && (Qk_in != TAG_NENHUM) && (Qk_in == cdb_tag)) begin
                ent_d[livre_idx].vk = cdb_valor;
                ent_d[livre_idx].qk = TAG_NENHUM;
            end else begin
                ent_d[livre_idx].vk = Vk_in;
                ent_d[livre_idx].qk = Qk_in;
            end
        end

        case (estado_q)
            OCIOSO: begin
                if (pronto_ok && UF_atoa) begin
                    nova_d     = 1'b1;
                    op_out_d   = ent_q[pronto_idx].op;
                    vj_out_d   = ent_q[pronto_idx].vj;
                    vk_out_d   = ent_q[pronto_idx].vk;
                    dest_out_d = ent_q[pronto_idx].dest;
                    qi_out_d   = TAG_BASE + TAG_W'(pronto_idx);
                    idx_d      = pronto_idx;
                    estado_d   = ESPERA;
                end
            end
            ESPERA: begin
                if (V_pronto) begin
                    ent_d[idx_q].busy = 1'b0;
                    estado_d          = OCIOSO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ent_q      <= '0;
            estado_q   <= OCIOSO;
            idx_q      <= '0;
            nova_q     <= 1'b0;
            op_out_q   <= '0;
            vj_out_q   <= '0;
            vk_out_q   <= '0;
            dest_out_q <= '0;
            qi_out_q   <= '0;
        end else begin
            ent_q      <= ent_d;
            estado_q   <= estado_d;
            idx_q      <= idx_d;
            nova_q     <= nova_d;
            op_out_q   <= op_out_d;
            vj_out_q   <= vj_out_d;
            vk_out_q   <= vk_out_d;
            dest_out_q <= dest_out_d;
            qi_out_q   <= qi_out_d;
        end
    end

    assign nova       = nova_q;
    assign opcode_out = op_out_q;
    assign Vj_out     = vj_out_q;
    assign Vk_out     = vk_out_q;
    assign dest_out   = dest_out_q;
    assign Qi_out     = qi_out_q;
endmodule
